// File: rtl/add_arb_pkg.sv
// Shared types and helpers for the round-robin adder arbiter.
// Holds the default parameters, the index-width helper and the tag
// record that follows each operation through the adder pipeline.
package add_arb_pkg;

  localparam int WIDTH_DEF   = 8;
  localparam int NREQ_DEF    = 4;
  localparam int LATENCY_DEF = 1;

  // The tag index field is sized for the largest legal requester count
  // (16), so one tag type serves every NREQ.
  localparam int TAG_IDX_W = 4;

  // Index width for n requesters; a single requester still gets one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic                 valid;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

endpackage

// File: rtl/add.sv
// Shared registered adder: out = (in0 + in1) mod 2^WIDTH after LATENCY clocks.
// Ports: clock; in0/in1 operands; out sum. No reset, no flow control --
// the caller tracks which outputs are meaningful.
module add #(
  parameter int WIDTH   = 8,
  parameter int LATENCY = 1
) (
  input  logic             clock,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  output logic [WIDTH-1:0] out
);

  logic [WIDTH-1:0] stage [LATENCY];

  // Carry out of the top bit is dropped by the WIDTH-bit destination.
  always_ff @(posedge clock) begin
    stage[0] <= in0 + in1;
    for (int s = 1; s < LATENCY; s++) begin
      stage[s] <= stage[s-1];
    end
  end

  assign out = stage[LATENCY-1];

endmodule

// File: rtl/add_rr_pick.sv
// Combinational round-robin picker: first eligible requester at or after ptr.
// Ports: elig (eligible mask), ptr (highest-priority index) -> grant_oh
// (one-hot or zero), grant_idx (binary index), any (a grant exists).
module add_rr_pick
  import add_arb_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int IDX_W = idx_w(NREQ)
) (
  input  logic [NREQ-1:0]  elig,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant_oh,
  output logic [IDX_W-1:0] grant_idx,
  output logic             any
);

  // Distance of the current best candidate from ptr, measured forward
  // with wrap; the eligible requester with the smallest distance wins.
  int best;

  always_comb begin
    grant_idx = '0;
    any       = 1'b0;
    best      = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      if (elig[i] && (((i + NREQ - int'(ptr)) % NREQ) < best)) begin
        best      = (i + NREQ - int'(ptr)) % NREQ;
        grant_idx = IDX_W'(i);
        any       = 1'b1;
      end
    end
  end

  always_comb begin
    grant_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant_oh[i] = any && (grant_idx == IDX_W'(i));
    end
  end

endmodule

// File: rtl/add_arbiter.sv
// Round-robin arbiter sharing one registered adder among NREQ requesters.
// Ports: clock, reset_n (sync, active-low); per requester req_valid/req_ready
// with packed operands req_in0/req_in1, and resp_valid/resp_ready/resp_data.
// A grant in cycle T yields resp_valid from T+LATENCY+1; each requester has
// at most one operation in flight or held, so a stalled responder blocks
// only itself.
module add_arbiter
  import add_arb_pkg::*;
#(
  parameter int WIDTH   = WIDTH_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int LATENCY = LATENCY_DEF
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_in0,
  input  logic [NREQ*WIDTH-1:0] req_in1,
  output logic [NREQ-1:0]       resp_valid,
  input  logic [NREQ-1:0]       resp_ready,
  output logic [NREQ*WIDTH-1:0] resp_data
);

  localparam int IDX_W = idx_w(NREQ);

  logic [NREQ-1:0]  pending;
  logic [NREQ-1:0]  elig;
  logic [NREQ-1:0]  grant_oh;
  logic [NREQ-1:0]  resp_hs;
  logic [NREQ-1:0]  capture_oh;
  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] grant_idx;
  logic             pick_any;
  logic             grant;
  logic [WIDTH-1:0] add_in0;
  logic [WIDTH-1:0] add_in1;
  logic [WIDTH-1:0] add_out;
  tag_t             tag_in;
  tag_t             tag_out;
  tag_t             tag_pipe [LATENCY];

  // A requester with an operation in flight or a held sum is masked out
  // until that sum is taken, which also keeps captures from overwriting.
  assign elig = req_valid & ~pending;

  add_rr_pick #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .elig      (elig),
    .ptr       (ptr),
    .grant_oh  (grant_oh),
    .grant_idx (grant_idx),
    .any       (pick_any)
  );

  // No handshakes are offered while reset is asserted.
  assign grant     = pick_any & reset_n;
  assign req_ready = reset_n ? grant_oh : '0;
  assign resp_hs   = resp_valid & resp_ready;

  // Steer the granted pair into the adder; idle cycles feed zeros.
  always_comb begin
    add_in0 = '0;
    add_in1 = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        add_in0 = req_in0[i*WIDTH +: WIDTH];
        add_in1 = req_in1[i*WIDTH +: WIDTH];
      end
    end
  end

  add #(
    .WIDTH   (WIDTH),
    .LATENCY (LATENCY)
  ) u_add (
    .clock (clock),
    .in0   (add_in0),
    .in1   (add_in1),
    .out   (add_out)
  );

  // Ownership tag travels alongside the adder pipeline, stage for stage.
  always_comb begin
    tag_in       = '0;
    tag_in.valid = grant;
    tag_in.idx   = TAG_IDX_W'(grant_idx);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      for (int s = 0; s < LATENCY; s++) begin
        tag_pipe[s] <= '0;
      end
    end else begin
      tag_pipe[0] <= tag_in;
      for (int s = 1; s < LATENCY; s++) begin
        tag_pipe[s] <= tag_pipe[s-1];
      end
    end
  end

  assign tag_out = tag_pipe[LATENCY-1];

  always_comb begin
    capture_oh = '0;
    for (int i = 0; i < NREQ; i++) begin
      capture_oh[i] = tag_out.valid && (tag_out.idx == TAG_IDX_W'(i));
    end
  end

  // Pointer, pending mask and response slots.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      ptr        <= '0;
      pending    <= '0;
      resp_valid <= '0;
      resp_data  <= '0;
    end else begin
      pending <= (pending | req_ready) & ~resp_hs;
      if (grant) begin
        ptr <= (grant_idx == IDX_W'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
      end
      // Capture and drain on different slots proceed independently; a
      // capture onto a held slot cannot happen thanks to the pending mask.
      for (int i = 0; i < NREQ; i++) begin
        if (capture_oh[i]) begin
          resp_valid[i]                 <= 1'b1;
          resp_data[i*WIDTH +: WIDTH]   <= add_out;
        end else if (resp_hs[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  a_grant_onehot : assert property (
    @(posedge clock) disable iff (!reset_n) $onehot0(req_ready));

  a_no_capture_on_held : assert property (
    @(posedge clock) disable iff (!reset_n) (capture_oh & resp_valid) == '0);

  a_no_grant_with_drain : assert property (
    @(posedge clock) disable iff (!reset_n) (req_ready & resp_hs) == '0);

endmodule

// File: tb/tb_add_arbiter.sv
`timescale 1ns/1ps
module tb_add_arbiter;

  localparam int W = 8;
  localparam int N = 4;
  localparam int L = 1;

  logic           clock = 1'b0;
  logic           reset_n;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_in0;
  logic [N*W-1:0] req_in1;
  logic [N-1:0]   resp_valid;
  logic [N-1:0]   resp_ready;
  logic [N*W-1:0] resp_data;

  always #5 clock = ~clock;

  add_arbiter #(.WIDTH(W), .NREQ(N), .LATENCY(L)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_in0    (req_in0),
    .req_in1    (req_in1),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    int         idx;
    logic [W-1:0] sum;
    int         left;
  } flight_t;

  flight_t      flight[$];
  int           m_ptr  = 0;
  logic [N-1:0] m_pend = '0;
  logic [N-1:0] m_val  = '0;
  logic [W-1:0] m_dat [N];
  bit           mon_en = 1'b0;
  logic [N-1:0] hs_q   = '0;
  int           rv_cnt = 0;
  int           cyc    = 0;

  // Winner is the first requester, scanning forward from the pointer,
  // that has a request and nothing outstanding.
  function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] p, input int ptr);
    for (int off = 0; off < N; off++) begin
      int c;
      c = (ptr + off) % N;
      if (v[c] && !p[c]) return c;
    end
    return -1;
  endfunction

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    int g;
    logic [N-1:0] exp_rdy;
    g = (reset_n === 1'b1) ? pick(req_valid, m_pend, m_ptr) : -1;
    exp_rdy = '0;
    if (g >= 0) exp_rdy[g] = 1'b1;
    if (mon_en) begin
      chk("req_ready", req_ready, exp_rdy);
      chk("resp_valid", resp_valid, m_val);
      for (int i = 0; i < N; i++) begin
        chk($sformatf("resp_data[%0d]", i), resp_data[i*W +: W], m_dat[i]);
      end
      if (resp_valid != '0) rv_cnt++;
    end
    hs_q = req_valid & req_ready;
    // advance model across the coming rising edge
    if (reset_n !== 1'b1) begin
      m_ptr  = 0;
      m_pend = '0;
      m_val  = '0;
      for (int i = 0; i < N; i++) m_dat[i] = '0;
      flight.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (m_val[i] && resp_ready[i]) begin
          m_val[i]  = 1'b0;
          m_pend[i] = 1'b0;
        end
      end
      for (int k = 0; k < flight.size(); k++) begin
        flight[k].left = flight[k].left - 1;
        if (flight[k].left == 0) begin
          m_val[flight[k].idx] = 1'b1;
          m_dat[flight[k].idx] = flight[k].sum;
        end
      end
      while (flight.size() > 0 && flight[0].left == 0) void'(flight.pop_front());
      if (g >= 0) begin
        flight_t f;
        f.idx  = g;
        f.sum  = req_in0[g*W +: W] + req_in1[g*W +: W];
        f.left = L;
        flight.push_back(f);
        m_pend[g] = 1'b1;
        m_ptr     = (g + 1) % N;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [N-1:0] keep;
  int           grants[$];

  // Advance n cycles; one-shot requesters drop valid after their handshake.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
      for (int i = 0; i < N; i++) begin
        if (hs_q[i]) begin
          grants.push_back(i);
          if (!keep[i]) req_valid[i] = 1'b0;
        end
      end
    end
  endtask

  task automatic set_op(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_in0[i*W +: W] = a;
    req_in1[i*W +: W] = b;
  endtask

  task automatic single(input string nm, input int i, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp);
    int t0;
    int tv;
    bit seen;
    set_op(i, a, b);
    req_valid[i] = 1'b1;
    t0   = cyc;
    tv   = 0;
    seen = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1);
      if (resp_valid[i]) begin
        seen = 1'b1;
        tv   = cyc;
        chk({nm, " sum"}, resp_data[i*W +: W], exp);
        chk({nm, " latency"}, tv - t0, L + 1);
      end
    end
    chk({nm, " response seen"}, seen, 1);
    step(1);
    chk({nm, " one cycle only"}, resp_valid[i], 1'b0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int rv0;
    int exp_rr[5];
    int n_one;
    int n_oth;
    bit seen;
    exp_rr = '{0, 1, 2, 3, 0};

    reset_n    = 1'b0;
    req_valid  = '0;
    req_in0    = '0;
    req_in1    = '0;
    resp_ready = '1;
    keep       = '0;
    step(3);
    reset_n = 1'b1;
    mon_en  = 1'b1;
    chk("reset resp_valid", resp_valid, 0);
    chk("reset resp_data", resp_data, 0);

    // Reset while requester 1's operation is inside the adder.
    rv0 = rv_cnt;
    set_op(1, 8'h06, 8'h01);
    req_valid[1] = 1'b1;
    step(1);
    reset_n = 1'b0;
    step(1);
    reset_n = 1'b1;
    step(4);
    chk("mid-reset no response", rv_cnt - rv0, 0);
    chk("mid-reset resp_data", resp_data, 0);
    set_op(0, 8'h01, 8'h01);
    set_op(1, 8'h02, 8'h02);
    req_valid = 4'b0011;
    #1;
    chk("mid-reset requester 0 first", req_ready, 4'b0001);
    step(6);

    single("single r2", 2, 8'h06, 8'h01, 8'h07);
    single("wrap r0", 0, 8'hFF, 8'h02, 8'h01);
    single("wrap r3", 3, 8'h80, 8'h80, 8'h00);

    // Round-robin with everybody streaming.
    for (int i = 0; i < N; i++) set_op(i, W'(8'h11 * (i + 1)), W'(8'h03 + i));
    grants.delete();
    keep      = '1;
    req_valid = '1;
    step(8);
    chk("rr grant count", grants.size() >= 5, 1);
    for (int k = 0; k < 5 && k < grants.size(); k++) begin
      chk($sformatf("rr grant %0d", k), grants[k], exp_rr[k]);
    end
    keep = '0;
    step(6);
    req_valid = '0;
    step(4);

    // Requester 1 withholds resp_ready; the others keep streaming.
    for (int i = 0; i < N; i++) set_op(i, W'(8'h10 * i + 1), 8'h05);
    resp_ready = 4'b1101;
    keep       = '1;
    req_valid  = '1;
    seen       = 1'b0;
    for (int k = 0; k < 10 && !seen; k++) begin
      step(1);
      if (resp_valid[1]) seen = 1'b1;
    end
    chk("bp r1 response seen", seen, 1);
    grants.delete();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("bp hold valid %0d", k), resp_valid[1], 1'b1);
      chk($sformatf("bp hold data %0d", k), resp_data[1*W +: W], 8'h16);
      step(1);
    end
    resp_ready[1] = 1'b1;
    step(1);
    n_one = 0;
    n_oth = 0;
    foreach (grants[k]) begin
      if (grants[k] == 1) n_one++;
      else n_oth++;
    end
    chk("bp r1 no regrant", n_one, 0);
    chk("bp others granted", n_oth, 6);
    keep = '0;
    step(6);
    req_valid  = '0;
    resp_ready = '1;
    step(4);

    // Capture for 3 coincides with the drain of 0.
    resp_ready = 4'b1110;
    set_op(0, 8'h01, 8'h02);
    req_valid[0] = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 6 && !seen; k++) begin
      step(1);
      if (resp_valid[0]) seen = 1'b1;
    end
    chk("simul r0 held", seen, 1);
    set_op(3, 8'h21, 8'h22);
    req_valid[3] = 1'b1;
    step(1);
    resp_ready[0] = 1'b1;
    step(1);
    chk("simul resp_valid", resp_valid, 4'b1000);
    chk("simul r3 sum", resp_data[3*W +: W], 8'h43);
    chk("simul r0 data kept", resp_data[0*W +: W], 8'h03);
    step(3);

    mon_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, compared=%0d", n_cmp);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/add_arbiter.md
# add_arbiter

Round-robin arbiter that shares one registered `add` instance among `NREQ` requesters. Each requester presents an operand pair with a valid/ready handshake. The block steers the granted pair into the adder and tracks the owner through the adder pipeline. It then holds the sum in that requester's response register until the requester accepts it. It sits between the requester-side logic and the single adder datapath.

## Interface
- `WIDTH`, 8: operand and sum width; passed to the `add` instance.
- `NREQ`, 4: number of requesters, 1..16.
- `LATENCY`, 1: clock cycles from `add` inputs to `add.out`; must match the `add` instance.

- `clock`  in  1: single clock, all state on rising edge.
- `reset_n`  in  1: reset is synchronous and active-low.
- `req_valid`  in  NREQ: requester i has an operand pair.
- `req_ready`  out  NREQ: one-hot grant; handshake when `req_valid[i] & req_ready[i]`.
- `req_in0`  in  NREQ*WIDTH: operand A, requester i at bits [i*WIDTH +: WIDTH].
- `req_in1`  in  NREQ*WIDTH: operand B, same packing.
- `resp_valid`  out  NREQ: sum for requester i is held.
- `resp_ready`  in  NREQ: requester i accepts its sum.
- `resp_data`  out  NREQ*WIDTH: per-requester sum, same packing.

## Operation
- Eligibility:
  - `elig[i] = req_valid[i] & ~pending[i]`.
  - `pending[i]` sets at grant of i.
  - `pending[i]` clears at the edge where `resp_valid[i] & resp_ready[i]`.
  - At most one operation per requester in flight or held.
- Grant:
  - Combinational round-robin over `elig`, starting at pointer `ptr`.
  - `req_ready` is one-hot or zero and may depend on `req_valid`.
  - At most one grant per cycle.
- Pointer:
  - On a grant to i, `ptr <= (i+1) mod NREQ`; wraps from NREQ-1 to 0.
  - `ptr` is unchanged when there is no grant.
- Datapath:
  - The granted pair is muxed combinationally onto `add.in0/in1`.
  - With no grant, the mux drives zeros.
  - Sum is `(in0+in1) mod 2^WIDTH`; the carry is dropped.
- Tag pipeline: `LATENCY` stages of {valid, idx}, loaded with {grant, granted index}.
- Capture:
  - When the tag output is valid with idx k, `resp_data[k] <= add.out` and `resp_valid[k] <= 1`.
  - `resp_valid[k]` stays high and `resp_data[k]` stays stable until the response handshake.
  - On handshake, `resp_valid[k] <= 0`; `resp_data` keeps its last value.
- Simultaneous events:
  - A capture for k and a handshake for j≠k in the same cycle are both honoured.
  - A capture for k while `resp_valid[k]` is high is impossible, because of the pending mask.
  - A grant for i and a response handshake for i in the same cycle cannot occur.
- Reset values (when `reset_n` is low at a rising edge):
  - `ptr` = 0, `pending` = 0, tag pipeline = 0, `resp_valid` = 0, `resp_data` = 0.
  - `req_ready` is 0 while `reset_n` is low.
  - In-flight operations are discarded and produce no response.
  - The `add` instance has no reset; its output is ignored unless tagged.

## Timing
- Handshake in cycle T gives `resp_valid[i]` high from cycle T+LATENCY+1; with LATENCY=1 that is T+2.
- Aggregate throughput is one operation per cycle when requests rotate.
- A single requester sustains at most one operation per LATENCY+2 cycles: grant T, response T+2, handshake T+2, eligible again T+3.
- A requester that keeps `resp_ready` low blocks only itself.
- Priority:
  - Requester 0 has highest priority after reset.
  - No requester waits more than NREQ-1 grants once eligible.

## Structure
- Package `add_arb_pkg`:
  - `IDX_W = $clog2(NREQ)` helper function (minimum 1).
  - Tag struct {valid, idx} typedef.
  - Default WIDTH/NREQ/LATENCY constants.
- Sub-module `add_rr_pick`:
  - Combinational one-hot round-robin picker.
  - Inputs: `elig`, `ptr`. Outputs: `grant_oh`, `grant_idx`, `any`.
- The existing `add` module is instantiated as the shared datapath.

## Test plan
- Reset mid-operation:
  - Grant requester 1 with 6+1, then pull `reset_n` low one cycle later.
  - Required: no `resp_valid` ever, `resp_data` = 0, `ptr` = 0, and requester 0 wins first after release.
- Single request:
  - Requester 2 sends in0=8'h06, in1=8'h01 at cycle T with `resp_ready` held high.
  - Required: `resp_valid[2]` high in T+2 only, `resp_data[2]` = 8'h07.
- Wrap-around:
  - Requester 0 sends 8'hFF + 8'h02.
  - Required: `resp_data[0]` = 8'h01, carry dropped.
- Round-robin:
  - All four requesters valid continuously with `resp_ready` high.
  - Required: grants 0,1,2,3,0 in consecutive eligible cycles, and each sum is returned to the correct index.
- Backpressure:
  - Requester 1 holds `resp_ready` low for 5 cycles while requesters 0, 2 and 3 stream.
  - Required: `resp_valid[1]` and `resp_data[1]` stay stable.
  - Required: requester 1 gets no new grant until the cycle after its handshake.
  - Required: the others proceed unaffected.
- Simultaneous capture and drain:
  - Requester 3's result is captured in the same cycle requester 0 handshakes its response.
  - Required: `resp_valid` = 4'b1000 in the next cycle.
